// File: rtl/ifetch_bus_bridge.sv
// Bridges IF fetch requests onto a valid/ready instruction bus; one fetch outstanding.
// Zero-wait latency: fetch_en at N -> fetch_hand_suc at N+3; flush/err/timeout never deliver stale data.
module ifetch_bus_bridge #(
  parameter int              XLEN           = 32,
  parameter int              TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0] NOP_INST       = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_flush,
  output logic [XLEN-1:0] fetch_inst,
  output logic            fetch_hand_suc,
  output logic            fetch_err,
  output logic            fetch_busy,
  output logic            ibus_req_valid,
  input  logic            ibus_req_ready,
  output logic [XLEN-1:0] ibus_req_addr,
  input  logic            ibus_rsp_valid,
  output logic            ibus_rsp_ready,
  input  logic [XLEN-1:0] ibus_rsp_data,
  input  logic            ibus_rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    RSP      = 3'd2,
    REQ_KILL = 3'd3,
    RSP_KILL = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            suc_q, suc_d;
  logic            err_q, err_d;
  logic            timed_out;
  logic [CW-1:0]   cnt_inc;

  assign timed_out = (cnt_q == TO_VAL);
  // Saturate so a flush landing on the timeout cycle cannot wrap the counter in RSP_KILL.
  assign cnt_inc   = timed_out ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    inst_d         = inst_q;
    suc_d          = 1'b0;
    err_d          = 1'b0;
    ibus_req_valid = 1'b0;
    ibus_rsp_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        ibus_rsp_ready = 1'b1;
        if (fetch_en && !fetch_flush) begin
          addr_d  = fetch_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        ibus_req_valid = 1'b1;
        if (ibus_req_ready) begin
          cnt_d   = '0;
          state_d = fetch_flush ? RSP_KILL : RSP;
        end else if (fetch_flush) begin
          state_d = REQ_KILL;
        end
      end
      REQ_KILL: begin
        ibus_req_valid = 1'b1;
        if (ibus_req_ready) begin
          cnt_d   = '0;
          state_d = RSP_KILL;
        end
      end
      RSP: begin
        ibus_rsp_ready = 1'b1;
        cnt_d          = cnt_inc;
        if (ibus_rsp_valid) begin
          state_d = IDLE;
          if (!fetch_flush) begin
            inst_d = ibus_rsp_err ? NOP_INST : ibus_rsp_data;
            suc_d  = 1'b1;
            err_d  = ibus_rsp_err;
          end
        end else if (fetch_flush) begin
          state_d = RSP_KILL;
        end else if (timed_out) begin
          inst_d  = NOP_INST;
          suc_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RSP_KILL: begin
        ibus_rsp_ready = 1'b1;
        cnt_d          = cnt_inc;
        if (ibus_rsp_valid || timed_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= NOP_INST;
      suc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      suc_q   <= suc_d;
      err_q   <= err_d;
    end
  end

  assign fetch_inst     = inst_q;
  assign fetch_hand_suc = suc_q;
  assign fetch_err      = err_q;
  assign fetch_busy     = (state_q != IDLE);
  assign ibus_req_addr  = addr_q;

endmodule

// File: tb/tb_ifetch_bus_bridge.sv
// Directed bench for ifetch_bus_bridge: stimulus pushes expected fetch results,
// a negedge monitor pops and compares on every fetch_hand_suc pulse.
module tb_ifetch_bus_bridge;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic [31:0] fetch_inst;
  logic        fetch_hand_suc;
  logic        fetch_err;
  logic        fetch_busy;
  logic        ibus_req_valid;
  logic        ibus_req_ready;
  logic [31:0] ibus_req_addr;
  logic        ibus_rsp_valid;
  logic        ibus_rsp_ready;
  logic [31:0] ibus_rsp_data;
  logic        ibus_rsp_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  ifetch_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(8), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_flush(fetch_flush), .fetch_inst(fetch_inst), .fetch_hand_suc(fetch_hand_suc),
    .fetch_err(fetch_err), .fetch_busy(fetch_busy), .ibus_req_valid(ibus_req_valid),
    .ibus_req_ready(ibus_req_ready), .ibus_req_addr(ibus_req_addr),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_ready(ibus_rsp_ready),
    .ibus_rsp_data(ibus_rsp_data), .ibus_rsp_err(ibus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fetch_hand_suc === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got fetch_hand_suc=1 inst=%h, expected no pulse (t=%0t)", fetch_inst, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_inst", fetch_inst, mon_e[31:0]);
        check("sb_err", 32'(fetch_err), 32'(mon_e[32]));
      end
    end else if (rst_n === 1'b1 && fetch_err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL lone_err: got fetch_err=1 without fetch_hand_suc, expected 0 (t=%0t)", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int req_wait, input int rsp_wait,
                          input logic [31:0] data, input logic err, input logic [31:0] exp_inst);
    exp_q.push_back({err, exp_inst});
    fetch_en   = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < req_wait; i++) begin
      fetch_addr = addr + 32'h1000 * 32'(i + 1);
      @(negedge clk);
      check("req_valid_held", 32'(ibus_req_valid), 32'd1);
      check("req_addr_stable", ibus_req_addr, addr);
      tick();
    end
    ibus_req_ready = 1'b1;
    @(negedge clk);
    check("req_valid", 32'(ibus_req_valid), 32'd1);
    check("req_addr", ibus_req_addr, addr);
    tick();
    ibus_req_ready = 1'b0;
    repeat (rsp_wait) tick();
    ibus_rsp_valid = 1'b1;
    ibus_rsp_data  = data;
    ibus_rsp_err   = err;
    tick();
    ibus_rsp_valid = 1'b0;
    ibus_rsp_err   = 1'b0;
    @(negedge clk);
    check("hand_suc_latency", 32'(fetch_hand_suc), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
    ibus_req_ready = 1'b0; ibus_rsp_valid = 1'b0; ibus_rsp_data = '0; ibus_rsp_err = 1'b0;
    #12;
    check("rst_inst", fetch_inst, NOP);
    check("rst_suc", 32'(fetch_hand_suc), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_req_addr", ibus_req_addr, 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_rsp_ready", 32'(ibus_rsp_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // zero-wait fetch, then request backpressure with a wandering fetch_addr
    do_fetch(32'h0000_0100, 0, 0, 32'h0010_0093, 1'b0, 32'h0010_0093);
    do_fetch(32'h0000_0104, 4, 1, 32'h0020_0113, 1'b0, 32'h0020_0113);

    // flush while request stalled: response must be swallowed
    fetch_en = 1'b1; fetch_addr = 32'h0000_0200;
    tick();
    fetch_en = 1'b0; fetch_flush = 1'b1;
    @(negedge clk);
    check("flush_busy", 32'(fetch_busy), 32'd1);
    tick();
    fetch_flush = 1'b0;
    @(negedge clk);
    check("kill_req_valid", 32'(ibus_req_valid), 32'd1);
    check("kill_req_addr", ibus_req_addr, 32'h0000_0200);
    tick();
    ibus_req_ready = 1'b1;
    tick();
    ibus_req_ready = 1'b0; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'hDEAD_BEEF;
    tick();
    ibus_rsp_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(fetch_busy), 32'd0);
    check("flush_inst_held", fetch_inst, 32'h0020_0113);
    tick();
    do_fetch(32'h0000_0204, 0, 0, 32'h0030_0193, 1'b0, 32'h0030_0193);

    // bus error returns NOP with fetch_err
    do_fetch(32'h0000_0300, 0, 1, 32'hFFFF_FFFF, 1'b1, NOP);

    // timeout: 9 cycles after RSP entry, then a stray late response
    exp_q.push_back({1'b1, NOP});
    fetch_en = 1'b1; fetch_addr = 32'h0000_0400;
    tick();
    fetch_en = 1'b0; ibus_req_ready = 1'b1;
    tick();
    ibus_req_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fetch_hand_suc === 1'b1) break;
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd9);
    tick();
    ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'h1234_5678;
    tick();
    ibus_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_busy", 32'(fetch_busy), 32'd0);
    check("late_rsp_inst", fetch_inst, NOP);
    tick();

    // reset asserted while in RSP
    do_fetch(32'h0000_0480, 1, 2, 32'h00A0_0513, 1'b0, 32'h00A0_0513);
    fetch_en = 1'b1; fetch_addr = 32'h0000_0500;
    tick();
    fetch_en = 1'b0; ibus_req_ready = 1'b1;
    tick();
    ibus_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_inst", fetch_inst, NOP);
    check("mid_rst_suc", 32'(fetch_hand_suc), 32'd0);
    check("mid_rst_err", 32'(fetch_err), 32'd0);
    check("mid_rst_req_addr", ibus_req_addr, 32'd0);
    check("mid_rst_busy", 32'(fetch_busy), 32'd0);
    check("mid_rst_req_valid", 32'(ibus_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_fetch(32'h0000_0600, 0, 0, 32'h0000_0297, 1'b0, 32'h0000_0297);

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
